// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - shared types and elaboration helpers for the shared S-box controller
package aes_sbox_pkg;

  // Controller phases: waiting for a data job, stepping through chunks, holding the result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Which requester a registered bank result belongs to (used by the output-register build)
  typedef struct packed {
    logic       valid;
    logic       is_key;
    logic [1:0] chunk;
  } owner_t;

  // Number of bank passes needed to cover a 16-byte state
  function automatic int chunk_count(input int num_sbox);
    return 16 / num_sbox;
  endfunction

  // Only bank sizes that evenly tile the state and hold a full key word are allowed
  function automatic bit num_sbox_legal(input int num_sbox);
    return (num_sbox == 4) || (num_sbox == 8) || (num_sbox == 16);
  endfunction

endpackage

// File: rtl/sbox_lane_bank.sv
// rtl/sbox_lane_bank.sv - NUM_SBOX combinational S-box lanes with per-lane direction
module sbox_lane_bank #(
  parameter int NUM_SBOX = 4
) (
  input  logic [NUM_SBOX*8-1:0] lane_in,
  input  logic [NUM_SBOX-1:0]   lane_encrypt,
  output logic [NUM_SBOX*8-1:0] lane_out
);

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    sbox_new_area u_sbox (
      .din     (lane_in[8*i +: 8]),
      .encrypt (lane_encrypt[i]),
      .dout    (lane_out[8*i +: 8])
    );
  end

endmodule

// File: rtl/sbox_new_area.sv
// rtl/sbox_new_area.sv - combined forward/inverse AES S-box sharing one GF(2^8) inverter
module sbox_new_area (
  input  logic [7:0] din,
  input  logic       encrypt,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; zero maps to zero naturally
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  logic [7:0] pre;
  logic [7:0] post;

  // Inverse direction undoes the affine map before the inverter, forward applies it after
  always_comb begin
    pre  = encrypt ? din : (rotl(din, 1) ^ rotl(din, 3) ^ rotl(din, 6) ^ 8'h05);
    post = gf_inv(pre);
    dout = encrypt ? (post ^ rotl(post, 1) ^ rotl(post, 2) ^ rotl(post, 3) ^ rotl(post, 4) ^ 8'h63)
                   : post;
  end

endmodule

// File: rtl/sbox_share_ctrl.sv
// rtl/sbox_share_ctrl.sv - time-shares an S-box bank between data state and key SubWord; SBOX_OUT_REG_EN adds a bank output register
module sbox_share_ctrl
  import aes_sbox_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         data_req_valid,
  output logic         data_req_ready,
  input  logic         data_req_encrypt,
  input  logic [127:0] data_in,
  output logic         data_rsp_valid,
  input  logic         data_rsp_ready,
  output logic [127:0] data_out,
  input  logic         key_req_valid,
  output logic         key_req_ready,
  input  logic [31:0]  key_in,
  output logic         key_rsp_valid,
  output logic [31:0]  key_out
);

  localparam int         C    = chunk_count(NUM_SBOX);
  localparam int         W    = NUM_SBOX * 8;
  localparam logic [2:0] C_L  = 3'(C);
  localparam logic [1:0] LAST = 2'(C - 1);

  if (!num_sbox_legal(NUM_SBOX)) begin : g_bad_num_sbox
    $error("sbox_share_ctrl: NUM_SBOX must be 4, 8 or 16");
  end

  state_t         state;
  logic [2:0]     chunk;
  logic           last_key;
  logic [127:0]   data_q;
  logic           enc_q;
  logic [1:0]     cidx;
  logic           key_grant;
  logic           data_slot;
  logic [W-1:0]   lane_in;
  logic [NUM_SBOX-1:0] lane_enc;
  logic [W-1:0]   lane_out;

  logic           commit_key;
  logic           commit_data;
  logic [1:0]     commit_idx;
  logic [W-1:0]   commit_val;

  // Key wins the bank, except that in RUN it may not take two cycles in a row
  assign key_req_ready  = key_req_valid && ((state != RUN) || !last_key);
  assign key_grant      = key_req_ready;
  assign data_req_ready = (state == IDLE);
  assign data_rsp_valid = (state == DONE);
  assign cidx           = chunk[1:0];
  assign data_slot      = (state == RUN) && (chunk < C_L) && !key_grant;

  // Bank input mux: key word on lanes 0..3 in forward direction, else the current data chunk
  always_comb begin
    lane_in  = '0;
    lane_enc = '1;
    if (key_grant) begin
      lane_in[31:0] = key_in;
    end else if (data_slot) begin
      lane_in  = data_q[cidx*W +: W];
      lane_enc = {NUM_SBOX{enc_q}};
    end
  end

  sbox_lane_bank #(.NUM_SBOX(NUM_SBOX)) u_bank (
    .lane_in      (lane_in),
    .lane_encrypt (lane_enc),
    .lane_out     (lane_out)
  );

`ifdef SBOX_OUT_REG_EN
  owner_t       owner_q;
  logic [W-1:0] lane_q;

  // Register bank outputs with a tag saying whether they belong to the key or to a data chunk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= '0;
      lane_q  <= '0;
    end else begin
      owner_q.valid  <= key_grant || data_slot;
      owner_q.is_key <= key_grant;
      owner_q.chunk  <= cidx;
      lane_q         <= lane_out;
    end
  end

  assign commit_key  = owner_q.valid && owner_q.is_key;
  assign commit_data = owner_q.valid && !owner_q.is_key;
  assign commit_idx  = owner_q.chunk;
  assign commit_val  = lane_q;
`else
  assign commit_key  = key_grant;
  assign commit_data = data_slot;
  assign commit_idx  = cidx;
  assign commit_val  = lane_out;
`endif

  // Controller FSM plus result registers; a job finishes when its last chunk commits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      chunk         <= 3'd0;
      last_key      <= 1'b0;
      data_q        <= '0;
      enc_q         <= 1'b0;
      data_out      <= '0;
      key_out       <= '0;
      key_rsp_valid <= 1'b0;
    end else begin
      last_key      <= key_grant;
      key_rsp_valid <= commit_key;
      if (commit_key)  key_out <= commit_val[31:0];
      if (commit_data) data_out[commit_idx*W +: W] <= commit_val;
      case (state)
        IDLE: begin
          if (data_req_valid) begin
            data_q <= data_in;
            enc_q  <= data_req_encrypt;
            chunk  <= 3'd0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (data_slot) chunk <= chunk + 3'd1;
          if (commit_data && (commit_idx == LAST)) state <= DONE;
        end
        DONE: begin
          if (data_rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
